// File: rtl/hs_ram_if.sv
// hs_ram_if: engine-side handshake bundle for the hiscore RAM arbiter
interface hs_ram_if #(parameter int AW = 12) ();
  logic          hs_req;
  logic          hs_grant;
  logic          hs_strobe;
  logic          hs_we;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_ack;
  logic [7:0]    hs_rdata;
  modport master (
    output hs_req, hs_strobe, hs_we, hs_addr, hs_wdata,
    input  hs_grant, hs_ack, hs_rdata
  );
  modport slave (
    input  hs_req, hs_strobe, hs_we, hs_addr, hs_wdata,
    output hs_grant, hs_ack, hs_rdata
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: pauses the CPU, then lends its work-RAM port to the hiscore engine
module hs_ram_arbiter #(
  parameter int AW      = 12,
  parameter int RAM_LAT = 2,
  parameter int SETTLE  = 4,
  parameter int GUARD   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  hs_ram_if.slave       hs,
  output logic          cpu_pause_req,
  input  logic          cpu_paused,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_wdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          timeout
);
  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE_WAIT, S_SETTLE, S_GRANT, S_ACCESS, S_RELEASE, S_ABORT
  } state_t;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          grant_q, grant_d;
  logic          pause_q, pause_d;
  logic          timeout_q, timeout_d;
  logic          ack_q, ack_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    wdata_q, wdata_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      grant_q   <= 1'b0;
      pause_q   <= 1'b0;
      timeout_q <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      grant_q   <= grant_d;
      pause_q   <= pause_d;
      timeout_q <= timeout_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    grant_d   = grant_q;
    pause_d   = pause_q;
    timeout_d = timeout_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE:
        if (hs.hs_req) begin
          pause_d   = 1'b1;
          timeout_d = 1'b0;
          tcnt_d    = 16'(TIMEOUT);
          state_d   = S_PAUSE_WAIT;
        end
      S_PAUSE_WAIT:
        if (!hs.hs_req) begin
          pause_d = 1'b0;
          state_d = S_IDLE;
        end else if (cpu_paused) begin
          cnt_d   = 4'(SETTLE);
          grant_d = (SETTLE == 0);
          state_d = (SETTLE == 0) ? S_GRANT : S_SETTLE;
        end else if (tcnt_q <= 16'd1) begin
          timeout_d = 1'b1;
          pause_d   = 1'b0;
          state_d   = S_ABORT;
        end else
          tcnt_d = tcnt_q - 16'd1;
      S_SETTLE:
        if (!hs.hs_req) begin
          cnt_d   = 4'(GUARD);
          pause_d = (GUARD != 0);
          state_d = (GUARD == 0) ? S_IDLE : S_RELEASE;
        end else if (!cpu_paused) begin
          tcnt_d  = 16'(TIMEOUT);
          state_d = S_PAUSE_WAIT;
        end else if (cnt_q <= 4'd1) begin
          grant_d = 1'b1;
          state_d = S_GRANT;
        end else
          cnt_d = cnt_q - 4'd1;
      S_GRANT:
        if (!hs.hs_req) begin
          grant_d = 1'b0;
          cnt_d   = 4'(GUARD);
          pause_d = (GUARD != 0);
          state_d = (GUARD == 0) ? S_IDLE : S_RELEASE;
        end else if (hs.hs_strobe) begin
          addr_d  = hs.hs_addr;
          we_d    = hs.hs_we;
          wdata_d = hs.hs_wdata;
          cnt_d   = 4'(RAM_LAT);
          state_d = S_ACCESS;
        end
      S_ACCESS:
        if (cnt_q <= 4'd1) begin
          ack_d   = 1'b1;
          rdata_d = we_q ? 8'h00 : ram_rdata;
          state_d = S_GRANT;
        end else
          cnt_d = cnt_q - 4'd1;
      S_RELEASE:
        if (cnt_q <= 4'd1) begin
          pause_d = 1'b0;
          state_d = S_IDLE;
        end else
          cnt_d = cnt_q - 4'd1;
      S_ABORT:
        if (!hs.hs_req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // the counter still holds RAM_LAT only in the first ACCESS cycle, so writes last one cycle
  assign ram_addr  = grant_q ? addr_q : cpu_addr;
  assign ram_wdata = grant_q ? wdata_q : cpu_wdata;
  assign ram_we    = grant_q ? (state_q == S_ACCESS && cnt_q == 4'(RAM_LAT) && we_q) : cpu_we;
  assign hs.hs_grant   = grant_q;
  assign hs.hs_ack     = ack_q;
  assign hs.hs_rdata   = rdata_q;
  assign cpu_pause_req = pause_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: random hiscore sessions checked against a memory scoreboard and latency arithmetic
module tb_hs_ram_arbiter;
  localparam int AW      = 12;
  localparam int RAM_LAT = 2;
  localparam int SETTLE  = 4;
  localparam int GUARD   = 4;
  localparam int TIMEOUT = 100;
  logic clk, reset;
  logic cpu_pause_req, cpu_paused, cpu_we, ram_we, timeout;
  logic [AW-1:0] cpu_addr, ram_addr;
  logic [7:0] cpu_wdata, ram_wdata, ram_rdata;
  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [int];
  int n_checks = 0;
  int n_fail = 0;
  hs_ram_if #(.AW(AW)) hs ();
  hs_ram_arbiter #(.AW(AW), .RAM_LAT(RAM_LAT), .SETTLE(SETTLE), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .hs(hs),
    .cpu_pause_req(cpu_pause_req), .cpu_paused(cpu_paused),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .timeout(timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mux_check(input string tag);
    cpu_addr  = 12'($urandom);
    cpu_wdata = 8'($urandom);
    cpu_we    = 1'b1;
    #1;
    check({tag, "_addr"}, 32'(ram_addr), 32'(cpu_addr));
    check({tag, "_we"}, 32'(ram_we), 32'd1);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'(cpu_wdata));
    cpu_we = 1'b0;
  endtask
  task automatic wait_grant();
    int n = 0;
    while (!hs.hs_grant && n < 50) begin
      tick();
      n++;
    end
    check("grant_lat", 32'(n), 32'(SETTLE + 1));
  endtask
  task automatic start_session(input int pdelay);
    hs.hs_req = 1'b1;
    tick();
    check("pause_req_on", 32'(cpu_pause_req), 32'd1);
    for (int i = 0; i < pdelay; i++) begin
      check("no_early_grant", 32'(hs.hs_grant), 32'd0);
      tick();
    end
    cpu_paused = 1'b1;
    wait_grant();
  endtask
  task automatic release_session();
    int n = 0;
    hs.hs_req = 1'b0;
    tick();
    check("grant_drop", 32'(hs.hs_grant), 32'd0);
    while (cpu_pause_req && n < 50) begin
      tick();
      n++;
    end
    check("guard_len", 32'(n), 32'(GUARD));
    cpu_paused = 1'b0;
    tick();
    mux_check("restored");
  endtask
  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input bit drop);
    int n = 1;
    int wes = 0;
    hs.hs_strobe = 1'b1;
    hs.hs_we     = we;
    hs.hs_addr   = a;
    hs.hs_wdata  = d;
    cpu_addr     = ~a;
    tick();
    hs.hs_strobe = 1'b0;
    hs.hs_addr   = 12'($urandom);
    hs.hs_wdata  = 8'($urandom);
    if (drop) hs.hs_req = 1'b0;
    check("acc_addr", 32'(ram_addr), 32'(a));
    if (we) check("acc_wdata", 32'(ram_wdata), 32'(d));
    while (!hs.hs_ack && n < 20) begin
      wes += int'(ram_we);
      hs.hs_strobe = 1'b1;
      tick();
      hs.hs_strobe = 1'b0;
      n++;
    end
    check("ack_lat", 32'(n), 32'(RAM_LAT + 1));
    check("we_cycles", 32'(wes), we ? 32'd1 : 32'd0);
    if (we) begin
      ref_mem[int'(a)] = d;
      check("wr_rdata", 32'(hs.hs_rdata), 32'd0);
    end else
      check("rd_data", 32'(hs.hs_rdata), 32'(ref_mem[int'(a)]));
    if (!drop) begin
      tick();
      check("ack_pulse", 32'(hs.hs_ack), 32'd0);
    end
  endtask
  initial begin
    int n;
    logic [AW-1:0] a;
    logic w;
    reset = 1'b1;
    hs.hs_req = 1'b0; hs.hs_strobe = 1'b0; hs.hs_we = 1'b0; hs.hs_addr = '0; hs.hs_wdata = '0;
    cpu_paused = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    repeat (3) tick();
    check("rst_grant", 32'(hs.hs_grant), 32'd0);
    check("rst_ack", 32'(hs.hs_ack), 32'd0);
    check("rst_rdata", 32'(hs.hs_rdata), 32'd0);
    check("rst_pause", 32'(cpu_pause_req), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();
    mux_check("idle");
    start_session(9);
    do_access(1'b1, 12'h3C0, 8'h5A, 1'b0);
    do_access(1'b0, 12'h3C0, 8'h00, 1'b0);
    check("read_5a", 32'(hs.hs_rdata), 32'h5A);
    release_session();
    hs.hs_req = 1'b1;
    tick();
    check("to_pause_on", 32'(cpu_pause_req), 32'd1);
    n = 0;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    check("timeout_len", 32'(n), 32'(TIMEOUT));
    check("to_pause_off", 32'(cpu_pause_req), 32'd0);
    repeat (3) tick();
    check("abort_no_grant", 32'(hs.hs_grant), 32'd0);
    hs.hs_req = 1'b0;
    tick();
    check("timeout_sticky", 32'(timeout), 32'd1);
    hs.hs_req = 1'b1;
    tick();
    check("timeout_clear", 32'(timeout), 32'd0);
    hs.hs_req = 1'b0;
    tick();
    check("cancel_pause", 32'(cpu_pause_req), 32'd0);
    hs.hs_req = 1'b1;
    tick();
    cpu_paused = 1'b1;
    repeat (2) tick();
    check("settle_no_grant", 32'(hs.hs_grant), 32'd0);
    cpu_paused = 1'b0;
    repeat (3) tick();
    check("lost_no_grant", 32'(hs.hs_grant), 32'd0);
    check("lost_pause_req", 32'(cpu_pause_req), 32'd1);
    cpu_paused = 1'b1;
    wait_grant();
    do_access(1'b0, 12'h3C0, 8'h00, 1'b1);
    release_session();
    for (int s = 0; s < 8; s++) begin
      start_session(int'($urandom_range(0, 20)));
      n = int'($urandom_range(2, 6));
      for (int i = 0; i < n; i++) begin
        a = 12'h3C0 + 12'($urandom_range(0, 7));
        w = !ref_mem.exists(int'(a)) || ($urandom_range(0, 1) == 1);
        do_access(w, a, 8'($urandom), (i == n - 1) && (s % 2 == 1));
      end
      release_session();
    end
    start_session(3);
    do_access(1'b1, 12'h3C1, 8'hA5, 1'b0);
    do_access(1'b0, 12'h3C1, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_grant", 32'(hs.hs_grant), 32'd0);
    check("midrst_pause", 32'(cpu_pause_req), 32'd0);
    check("midrst_rdata", 32'(hs.hs_rdata), 32'd0);
    check("midrst_ack", 32'(hs.hs_ack), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    hs.hs_req = 1'b0;
    cpu_paused = 1'b0;
    tick();
    mux_check("after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game's work-RAM port between the running CPU and the hiscore save/restore engine.
- Before handing the port to the engine, the block asks the CPU to pause, waits for the CPU to acknowledge and for its bus to settle, then multiplexes the engine's byte accesses onto the RAM.
- On release it hands the port back and drops the pause request after a guard interval.
- Sits between the hiscore engine, the pause logic and the core's RAM, all in the clk_sys domain.

Parameters:
- AW, 12, RAM address width.
- RAM_LAT, 2, cycles from RAM address/we valid to ram_rdata valid (1..7).
- SETTLE, 4, cycles to wait after cpu_paused rises before granting (0..15).
- GUARD, 4, cycles pause stays requested after the grant is dropped (0..15).
- TIMEOUT, 65535, cycles to wait for cpu_paused before aborting (16-bit counter).

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- hs_req  in  1  engine requests ownership of the RAM port; held high for the whole session.
- hs_grant  out  1  engine owns the port.
- hs_strobe  in  1  one-cycle access start; honoured only while hs_grant=1 and not busy.
- hs_we  in  1  write when 1, read when 0 (sampled with hs_strobe).
- hs_addr  in  AW  access address (sampled with hs_strobe).
- hs_wdata  in  8  write data (sampled with hs_strobe).
- hs_ack  out  1  one-cycle pulse: access complete.
- hs_rdata  out  8  read data, valid in the hs_ack cycle.
- cpu_pause_req  out  1  request the CPU to halt.
- cpu_paused  in  1  CPU is halted (pause acknowledge).
- cpu_addr  in  AW  CPU RAM address.
- cpu_we  in  1  CPU RAM write enable.
- cpu_wdata  in  8  CPU write data.
- ram_addr  out  AW  RAM address to the array.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data.
- timeout  out  1  sticky flag: CPU failed to pause; cleared on reset or on the next hs_req rising edge.

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high.
- Reset values: state=IDLE; hs_grant=0; hs_ack=0; hs_rdata=0; cpu_pause_req=0; timeout=0; all counters=0.
- RAM mux (combinational):
  - With hs_grant=0: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - With hs_grant=1: the RAM is driven from latched engine registers, and ram_we can be 1 only in the first ACCESS cycle of a write.
- IDLE:
  - On hs_req=1: cpu_pause_req<=1, clear timeout, load the timeout counter, go to PAUSE_WAIT.
- PAUSE_WAIT:
  - On cpu_paused=1: load the settle counter, go to SETTLE.
  - Else decrement the timeout counter. At 0: timeout<=1, cpu_pause_req<=0, go to ABORT.
  - If hs_req drops: cpu_pause_req<=0, go to IDLE.
- SETTLE:
  - Count SETTLE cycles, then hs_grant<=1 and go to GRANT. Grant latency from cpu_paused rising is SETTLE+1 cycles.
  - If cpu_paused drops: return to PAUSE_WAIT with the timeout counter reloaded.
  - If hs_req drops: go to RELEASE.
- GRANT:
  - On hs_strobe: latch addr/we/wdata, load the latency counter with RAM_LAT, go to ACCESS.
  - If hs_req=0 (and no strobe): hs_grant<=0, load the guard counter, go to RELEASE.
  - hs_strobe and hs_req=0 in the same cycle: the strobe is ignored and release proceeds.
- ACCESS:
  - Write: ram_we=1 for exactly the first ACCESS cycle.
  - Count RAM_LAT cycles, then hs_ack<=1, hs_rdata<=ram_rdata (reads; writes return 0), return to GRANT.
  - Access latency from strobe to ack is RAM_LAT+1 cycles.
  - Strobes during ACCESS are ignored.
  - hs_req dropping mid-access: the access completes and is acked, then release proceeds.
- RELEASE:
  - hs_grant=0; count GUARD cycles, then cpu_pause_req<=0, go to IDLE.
  - A new hs_req during RELEASE is not served until IDLE.
- ABORT:
  - Hold until hs_req=0, then go to IDLE. hs_grant is never asserted.
- cpu_paused dropping during GRANT or ACCESS is ignored. The CPU must honour cpu_pause_req.
- Reset mid-session:
  - Immediate return to IDLE with hs_grant=0 and cpu_pause_req=0 on the next edge.
  - Any in-flight write is cut to at most the one cycle already issued.

Test Plan:
1. Defaults (SETTLE=4, RAM_LAT=2):
   - Stimulus: hs_req=1; cpu_paused rises 10 cycles later.
   - Required: cpu_pause_req=1 one cycle after hs_req; hs_grant=1 exactly 5 cycles after cpu_paused.
   - Required: ram_addr follows cpu_addr until the grant, then follows the latched engine address.
2. Write then read while granted:
   - Stimulus: write 0x5A to 0x3C0, then read 0x3C0.
   - Required: one ram_we cycle at address 0x3C0; hs_ack 3 cycles after each strobe; the read returns hs_rdata=0x5A.
3. Release:
   - Stimulus: drop hs_req in GRANT.
   - Required: hs_grant=0 next cycle; cpu_pause_req falls GUARD=4 cycles later; the CPU path is restored.
4. Timeout (TIMEOUT=100):
   - Stimulus: cpu_paused is never raised.
   - Required: timeout=1 and cpu_pause_req=0 after 100 cycles; hs_grant stays 0; timeout clears on the next hs_req rising edge.
5. Release during an access:
   - Stimulus: hs_req falls during an ACCESS read.
   - Required: hs_ack still pulses with the correct data, then release.
   - Stimulus: reset asserted in GRANT.
   - Required: all outputs return to reset values next edge.
6. Pause lost during SETTLE:
   - Stimulus: cpu_paused drops during SETTLE.
   - Required: no grant; the block returns to PAUSE_WAIT and grants SETTLE+1 cycles after cpu_paused re-rises.
